// File: rtl/apb_sram_slave.sv
// APB slave backed by a byte-strobed register memory with programmable wait states,
// a read-only low region and error reporting for bad or protected accesses.
module apb_sram_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0,
    parameter int RO_WORDS    = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR
);

    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int ALIGN_W = $clog2(STRB_W);
    localparam int IDX_W   = $clog2(DEPTH);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state, state_next;
    logic [3:0]              wait_cnt, wait_cnt_next;
    logic                    capture;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       strb_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [IDX_W-1:0]        mem_idx;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    ro_hit;
    logic                    err;
    logic                    active;
    logic                    done;
    logic                    commit;

    // Decode the captured address; DEPTH is a power of two so any bit above the index is out of range
    assign word_idx     = addr_q >> ALIGN_W;
    assign mem_idx      = IDX_W'(word_idx);
    assign out_of_range = (word_idx >> IDX_W) != '0;
    assign ro_hit       = write_q && ({1'b0, mem_idx} < (IDX_W+1)'(RO_WORDS));
    assign err          = out_of_range || misaligned || ro_hit;

    if (ALIGN_W > 0) begin : g_align
        assign misaligned = |addr_q[ALIGN_W-1:0];
    end else begin : g_noalign
        assign misaligned = 1'b0;
    end

    // A dropped PSEL/PENABLE in ACCESS kills the transfer, so completion also needs both high
    assign active  = (state == ACCESS) && PSEL && PENABLE;
    assign done    = active && (wait_cnt == 4'd0);
    assign commit  = done && write_q && !err;

    assign PREADY  = done;
    assign PSLVERR = done && err;
    assign PRDATA  = (done && !write_q && !err) ? mem[mem_idx] : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (capture) begin
                addr_q  <= PADDR;
                write_q <= PWRITE;
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
            end
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        capture       = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_next    = ACCESS;
                    wait_cnt_next = 4'(WAIT_CYCLES);
                    capture       = 1'b1;
                end
            end
            ACCESS: begin
                if (!active) begin
                    state_next    = IDLE;
                    wait_cnt_next = 4'd0;
                end else if (wait_cnt != 4'd0) begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset seeds every word with its own index
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_WIDTH'(i);
            end
        end else if (commit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (strb_q[b]) begin
                    mem[mem_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_sram_slave.sv
// Randomized bench for apb_sram_slave: two instances (no waits / three waits with a read-only
// region) share one bus and are compared against a word-array reference model.
module tb_apb_sram_slave;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [1:0]  ready_v, err_v;
    logic [31:0] rdata_v [2];

    int checkCount = 0;
    int passCount  = 0;

    int          waitOf [2] = '{0, 3};
    int          roOf   [2] = '{0, 4};
    logic [31:0] model  [2][256];

    apb_sram_slave #(.WAIT_CYCLES(0), .RO_WORDS(0)) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(ready_v[0]), .PRDATA(rdata_v[0]), .PSLVERR(err_v[0])
    );

    apb_sram_slave #(.WAIT_CYCLES(3), .RO_WORDS(4)) dut1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(ready_v[1]), .PRDATA(rdata_v[1]), .PSLVERR(err_v[1])
    );

    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic checkIdle(input string tag);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s d%0d ready", tag, d), 64'(ready_v[d]), 64'd0);
            checkOutput($sformatf("%s d%0d err", tag, d), 64'(err_v[d]), 64'd0);
            checkOutput($sformatf("%s d%0d rdata", tag, d), 64'(rdata_v[d]), 64'd0);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) model[d][i] = 32'(i);
    endtask

    function automatic logic modelErr(input int d, input logic wr, input logic [31:0] addr);
        longint unsigned idx = 64'(addr) / 4;
        return (idx >= 256) || (addr % 4 != 0) || (wr && idx < 64'(roOf[d]));
    endfunction

    // One APB transfer; abortAt > 0 drops PSEL on that access cycle
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input int abortAt);
        logic expReady, expErr;
        logic [31:0] expData;
        int idx;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
        @(negedge PCLK);
        for (int d = 0; d < 2; d++)
            checkOutput($sformatf("setup d%0d ready", d), 64'(ready_v[d]), 64'd0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PWRITE = 1'($urandom); PADDR = $urandom; PWDATA = $urandom; PSTRB = 4'($urandom);
        for (int a = 1; a <= 4; a++) begin
            if (a == abortAt) PSEL = 1'b0;
            @(negedge PCLK);
            for (int d = 0; d < 2; d++) begin
                expReady = (a == waitOf[d] + 1) && (abortAt == 0 || a < abortAt);
                expErr   = expReady && modelErr(d, wr, addr);
                idx      = int'(addr[9:2]);
                expData  = (expReady && !wr && !expErr) ? model[d][idx] : 32'd0;
                checkOutput($sformatf("a%0d d%0d ready @%h", a, d, addr), 64'(ready_v[d]), 64'(expReady));
                checkOutput($sformatf("a%0d d%0d err @%h", a, d, addr), 64'(err_v[d]), 64'(expErr));
                checkOutput($sformatf("a%0d d%0d rdata @%h", a, d, addr), 64'(rdata_v[d]), 64'(expData));
                if (expReady && wr && !expErr)
                    for (int b = 0; b < 4; b++)
                        if (strb[b]) model[d][idx][b*8 +: 8] = wdata[b*8 +: 8];
            end
            @(posedge PCLK); #1;
        end
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        logic [31:0] addr;
        int sel, abortAt;
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        modelReset();
        @(negedge PCLK);
        checkIdle("reset");
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Directed vectors from the block's worked examples
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 0);
        applyStimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 0);
        applyStimulus(1'b0, 32'h400, 32'h0, 4'h0, 0);
        applyStimulus(1'b1, 32'h06, 32'h12345678, 4'hF, 0);
        applyStimulus(1'b0, 32'h04, 32'h0, 4'h0, 0);
        applyStimulus(1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, 0);
        applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 0);
        applyStimulus(1'b1, 32'h10, 32'h55AA55AA, 4'hF, 0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 0);
        applyStimulus(1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, 0);
        applyStimulus(1'b0, 32'h14, 32'h0, 4'h0, 0);
        applyStimulus(1'b1, 32'h18, 32'hCAFEF00D, 4'hF, 1);
        applyStimulus(1'b0, 32'h18, 32'h0, 4'h0, 0);

        // Reset in the middle of a waited write must leave memory at its seed values
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h30; PWDATA = 32'hDEADBEEF; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #2;
        PRESETn = 1'b0;
        #1;
        checkIdle("midreset");
        modelReset();
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, 0);

        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      addr = {22'd0, 8'($urandom), 2'b00};
            else if (sel == 7) addr = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
            else if (sel == 8) addr = 32'h400 + {20'd0, 10'($urandom), 2'b00};
            else               addr = {27'd0, 3'($urandom), 2'b00};
            abortAt = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 4) : 0;
            applyStimulus(1'($urandom), addr, $urandom, 4'($urandom), abortAt);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
